// File: rtl/reg_read_port.sv
// rtl/reg_read_port.sv - queued register read port: captures src[rd_sel] into a FIFO, head on dout.
// Optional READ_PARITY_EN adds dout_par, the XOR of the head data, computed at capture time.
module reg_read_port #(
   parameter int WIDTH = 16,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [WIDTH-1:0]         src0,
   input  logic [WIDTH-1:0]         src1,
   input  logic [WIDTH-1:0]         src2,
   input  logic [WIDTH-1:0]         src3,
   input  logic                     rd_req,
   input  logic [1:0]               rd_sel,
   output logic                     req_ready,
   output logic [WIDTH-1:0]         dout,
   output logic [1:0]               dout_tag,
   output logic                     dout_valid,
   input  logic                     dout_ready,
   output logic [$clog2(DEPTH):0]   count,
`ifdef READ_PARITY_EN
   output logic                     dout_par,
`endif
   output logic                     ovf_err
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic [1:0]       tag_q [DEPTH];
   logic [1:0]       tag_d [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic             ovf_q, ovf_d;
   logic [WIDTH-1:0] dout_q, dout_d;
   logic [1:0]       dout_tag_q, dout_tag_d;
   logic [WIDTH-1:0] src_sel;
   logic             push;
   logic             pop;
`ifdef READ_PARITY_EN
   logic             par_q [DEPTH];
   logic             par_d [DEPTH];
   logic             dout_par_q, dout_par_d;
`endif

   assign req_ready  = (count_q < FULL_CNT);
   assign dout_valid = (count_q != '0);
   assign push       = rd_req & req_ready;
   assign pop        = dout_valid & dout_ready;

   always_comb begin
      src_sel = src0;
      case (rd_sel)
         2'd0: src_sel = src0;
         2'd1: src_sel = src1;
         2'd2: src_sel = src2;
         2'd3: src_sel = src3;
         default: src_sel = src0;
      endcase
   end

   always_comb begin
      mem_d      = mem_q;
      tag_d      = tag_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;
      ovf_d      = ovf_q | (rd_req & ~req_ready);
      dout_d     = dout_q;
      dout_tag_d = dout_tag_q;
`ifdef READ_PARITY_EN
      par_d      = par_q;
      dout_par_d = dout_par_q;
`endif
      if (push) begin
         mem_d[wr_ptr_q] = src_sel;
         tag_d[wr_ptr_q] = rd_sel;
`ifdef READ_PARITY_EN
         par_d[wr_ptr_q] = ^src_sel;
`endif
         wr_ptr_d = wr_ptr_q + AW'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + AW'(1);
      end
      case ({push, pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
      // Preload the head of the post-update queue so dout is a plain flop; hold when empty.
      if (count_d != '0) begin
         dout_d     = mem_d[rd_ptr_d];
         dout_tag_d = tag_d[rd_ptr_d];
`ifdef READ_PARITY_EN
         dout_par_d = par_d[rd_ptr_d];
`endif
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
            tag_q[i] <= '0;
`ifdef READ_PARITY_EN
            par_q[i] <= 1'b0;
`endif
         end
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         ovf_q      <= 1'b0;
         dout_q     <= '0;
         dout_tag_q <= '0;
`ifdef READ_PARITY_EN
         dout_par_q <= 1'b0;
`endif
      end else begin
         mem_q      <= mem_d;
         tag_q      <= tag_d;
`ifdef READ_PARITY_EN
         par_q      <= par_d;
         dout_par_q <= dout_par_d;
`endif
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         ovf_q      <= ovf_d;
         dout_q     <= dout_d;
         dout_tag_q <= dout_tag_d;
      end
   end

   assign dout     = dout_q;
   assign dout_tag = dout_tag_q;
   assign count    = count_q;
   assign ovf_err  = ovf_q;
`ifdef READ_PARITY_EN
   assign dout_par = dout_par_q;
`endif

endmodule
